// File: rtl/seq_div.sv
// Sequential restoring divider: one shift-subtract step per clock, start/done handshake.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands and results (truncating division).
module seq_div #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int            CW        = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;

  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH+1:0] w_rem_sh;
  logic [WIDTH+1:0] w_diff;
  logic             w_ge;
  logic             w_dbz;
  logic [WIDTH-1:0] w_q_res;
  logic [WIDTH-1:0] w_r_res;

`ifdef SEQ_DIV_SIGNED_EN
  logic [WIDTH-1:0] r_a_raw;
  logic             r_neg_q;
  logic             r_neg_r;

  assign w_a_mag = a[WIDTH-1] ? -a : a;
  assign w_b_mag = b[WIDTH-1] ? -b : b;
  // Most-negative / -1 needs no special case: the magnitude quotient 2^(WIDTH-1)
  // already reads back as the most-negative pattern with a positive sign.
  assign w_q_res = w_dbz   ? '1      : (r_neg_q ? -r_dvd : r_dvd);
  assign w_r_res = w_dbz   ? r_a_raw :
                   (r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0]);
`else
  assign w_a_mag = a;
  assign w_b_mag = b;
  // With a zero divisor no steps run, so the dividend register still holds a.
  assign w_q_res = w_dbz ? '1    : r_dvd;
  assign w_r_res = w_dbz ? r_dvd : r_rem[WIDTH-1:0];
`endif

  // Trial subtract on the shifted {remainder, dividend MSB}; the top bit is the borrow.
  assign w_rem_sh = {r_rem, r_dvd[WIDTH-1]};
  assign w_diff   = w_rem_sh - {2'b00, r_dvs};
  assign w_ge     = ~w_diff[WIDTH+1];
  assign w_dbz    = (r_dvs == '0);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = (b == '0) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (r_cnt == LAST_STEP) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_rem   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_cnt   <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      r_a_raw <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dvd   <= w_a_mag;
            r_dvs   <= w_b_mag;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_dbz   <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            r_a_raw <= a;
            r_neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
            r_neg_r <= a[WIDTH-1];
`endif
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_CALC: begin
          r_rem <= w_ge ? w_diff[WIDTH:0] : w_rem_sh[WIDTH:0];
          r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt + 1'b1;
        end
        S_DONE: begin
          r_q    <= w_q_res;
          r_r    <= w_r_res;
          r_dbz  <= w_dbz;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign q           = r_q;
  assign r           = r_r;
  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: vector table, random ops against an arithmetic model,
// continuous-start and reset-mid-operation sequences.
module tb_seq_div;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         clr_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int           total = 0;
  int           bad   = 0;
  logic [W-1:0] prev_q;
  logic [W-1:0] prev_r;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } vec_t;

  vec_t tbl[$];

  seq_div #(.WIDTH(W)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .q          (q),
    .r          (r),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Division from the arithmetic rules, not from the shift-subtract algorithm.
  function automatic void model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                output logic [W-1:0] mq, output logic [W-1:0] mr,
                                output logic md);
    int sa;
    int sb;
    if (tb_ == '0) begin
      mq = '1;
      mr = ta;
      md = 1'b1;
    end else begin
`ifdef SEQ_DIV_SIGNED_EN
      sa = ta[W-1] ? int'(ta) - (1 << W) : int'(ta);
      sb = tb_[W-1] ? int'(tb_) - (1 << W) : int'(tb_);
`else
      sa = int'(ta);
      sb = int'(tb_);
`endif
      mq = W'(sa / sb);
      mr = W'(sa % sb);
      md = 1'b0;
    end
  endfunction

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic ed, input string tag);
    int edges;
    int lat;
    logic seen;
    lat  = ed ? 1 : W + 1;
    seen = 1'b0;
    @(negedge clk);
    a = ta; b = tb_; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, " busy_after_accept"}, busy, 1);
    edges = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      edges = k;
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      chk({tag, " busy_calc"}, busy, 1);
      chk({tag, " q_hold"}, q, prev_q);
      chk({tag, " r_hold"}, r, prev_r);
    end
    if (!seen) begin
      chk({tag, " done_timeout"}, 0, 1);
      return;
    end
    $display("op %s a=%0d b=%0d q=%0d r=%0d dbz=%0d edges=%0d", tag, ta, tb_, q, r, div_by_zero, edges);
    chk({tag, " latency"}, edges, lat);
    chk({tag, " q"}, q, eq);
    chk({tag, " r"}, r, er);
    chk({tag, " dbz"}, div_by_zero, ed);
    chk({tag, " busy_done"}, busy, 1);
    prev_q = eq;
    prev_r = er;
    @(posedge clk); #1;
    chk({tag, " done_pulse_end"}, done, 0);
    chk({tag, " busy_idle"}, busy, 0);
    chk({tag, " q_idle_hold"}, q, eq);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] mq, mr, ta, tb_;
    logic         md;
    logic [W-1:0] ca[$];
    logic [W-1:0] cb[$];

`ifdef SEQ_DIV_SIGNED_EN
    tbl.push_back('{4'd9,  4'd2,  4'd13, 4'd15, 1'b0});  // -7 / 2
    tbl.push_back('{4'd8,  4'd15, 4'd8,  4'd0,  1'b0});  // -8 / -1
    tbl.push_back('{4'd7,  4'd0,  4'd15, 4'd7,  1'b1});
    tbl.push_back('{4'd8,  4'd2,  4'd12, 4'd0,  1'b0});  // -8 / 2
    tbl.push_back('{4'd7,  4'd14, 4'd13, 4'd1,  1'b0});  // 7 / -2
    tbl.push_back('{4'd5,  4'd3,  4'd1,  4'd2,  1'b0});
    tbl.push_back('{4'd15, 4'd15, 4'd1,  4'd0,  1'b0});  // -1 / -1
    tbl.push_back('{4'd6,  4'd13, 4'd14, 4'd0,  1'b0});  // 6 / -3
`else
    tbl.push_back('{4'd13, 4'd4,  4'd3,  4'd1,  1'b0});
    tbl.push_back('{4'd15, 4'd15, 4'd1,  4'd0,  1'b0});
    tbl.push_back('{4'd2,  4'd7,  4'd0,  4'd2,  1'b0});
    tbl.push_back('{4'd15, 4'd1,  4'd15, 4'd0,  1'b0});
    tbl.push_back('{4'd7,  4'd0,  4'd15, 4'd7,  1'b1});
    tbl.push_back('{4'd8,  4'd2,  4'd4,  4'd0,  1'b0});
    tbl.push_back('{4'd0,  4'd5,  4'd0,  4'd0,  1'b0});
    tbl.push_back('{4'd9,  4'd3,  4'd3,  4'd0,  1'b0});
    tbl.push_back('{4'd1,  4'd15, 4'd0,  4'd1,  1'b0});
    tbl.push_back('{4'd14, 4'd3,  4'd4,  4'd2,  1'b0});
`endif

    clr_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #12;
    chk("reset q", q, 0);
    chk("reset r", r, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset dbz", div_by_zero, 0);
    @(negedge clk);
    clr_n  = 1'b1;
    prev_q = '0;
    prev_r = '0;

    foreach (tbl[i]) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dbz, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 120; i++) begin
      ta  = W'($urandom_range(0, (1 << W) - 1));
      tb_ = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom_range(0, (1 << W) - 1));
      model(ta, tb_, mq, mr, md);
      do_op(ta, tb_, mq, mr, md, $sformatf("rnd%0d", i));
    end

    // start held high: operands scrambled between accept edges must be ignored
    ca = '{4'd13, 4'd11, 4'd6, 4'd14, 4'd15};
    cb = '{4'd4,  4'd3,  4'd5, 4'd3,  4'd1};
    @(negedge clk);
    a = ca[0]; b = cb[0]; start = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < ca.size(); k++) begin
      model(ca[k], cb[k], mq, mr, md);
      for (int c = 1; c <= W + 1; c++) begin
        @(negedge clk);
        a = W'($urandom); b = W'($urandom);
        @(posedge clk); #1;
        if (c < W + 1) begin
          chk($sformatf("cont%0d early_done", k), done, 0);
          chk($sformatf("cont%0d busy", k), busy, 1);
        end else begin
          $display("op cont%0d a=%0d b=%0d q=%0d r=%0d done=%0d", k, ca[k], cb[k], q, r, done);
          chk($sformatf("cont%0d done", k), done, 1);
          chk($sformatf("cont%0d q", k), q, mq);
          chk($sformatf("cont%0d r", k), r, mr);
        end
      end
      @(negedge clk);
      if (k + 1 < ca.size()) begin
        a = ca[k + 1]; b = cb[k + 1];
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      chk($sformatf("cont%0d done_single", k), done, 0);
      chk($sformatf("cont%0d busy_next", k), busy, (k + 1 < ca.size()) ? 1 : 0);
      prev_q = mq;
      prev_r = mr;
    end

    // reset during the second CALC cycle
    @(negedge clk);
    a = 4'd13; b = 4'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    clr_n = 1'b0;
    #1;
    $display("op reset_mid_calc q=%0d r=%0d busy=%0d done=%0d", q, r, busy, done);
    chk("midrst q", q, 0);
    chk("midrst r", r, 0);
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst dbz", div_by_zero, 0);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    clr_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("midrst no_done", done, 0);
      chk("midrst idle_busy", busy, 0);
    end
    prev_q = '0;
    prev_r = '0;
    model(4'd9, 4'd3, mq, mr, md);
    do_op(4'd9, 4'd3, mq, mr, md, "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
